// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default divider, data-width limits
// and the parity helper. Used by the TX core and, later, the RX core.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // 50 MHz system clock / 115200 baud
    localparam int UART_DEF_CLK_DIV = 434;
    localparam int UART_DATA_W_MIN  = 5;
    localparam int UART_DATA_W_MAX  = 9;

    // Unused upper bits must be zero; they then do not disturb the XOR.
    function automatic logic uart_parity(input logic [UART_DATA_W_MAX-1:0] data,
                                         input logic                       odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: a counter 0..CLK_DIV-1 that wraps, with a tick on the
// last count. A synchronous clear restarts the period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV = UART_DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("uart_baud_gen: CLK_DIV must be at least 2");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and wrap at CNT_MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_core.sv
// Parametrised UART transmitter with built-in baud divider and valid/ready input.
// Define UART_TX_PARITY_EN to add one parity bit (even/odd per PARITY_ODD).
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = UART_DEF_CLK_DIV,
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);

    if (CLK_DIV < 2 || DATA_W < UART_DATA_W_MIN || DATA_W > UART_DATA_W_MAX ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_tx_core: illegal CLK_DIV, DATA_W, STOP_BITS or PARITY_ODD");
    end

    localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_W - 1);
    localparam logic [3:0] LAST_STOP_IDX = 4'(STOP_BITS - 1);

    uart_tx_state_t    state_q;
    uart_tx_state_t    state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [3:0]        bit_idx_q;
    logic [3:0]        bit_idx_d;
    logic              o_tx_q;
    logic              o_tx_d;
    logic              o_done_q;
    logic              o_done_d;
    logic              accept_s;
    logic              tick_s;

    assign accept_s = i_valid && (state_q == IDLE);

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (accept_s),
        .tick  (tick_s)
    );

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_ODD_BIT = 1'(PARITY_ODD);

    logic parity_q;
    logic parity_d;

    // The shifter consumes the word, so the parity bit is computed at accept.
    always_comb begin
        if (accept_s) begin
            parity_d = uart_parity(UART_DATA_W_MAX'(i_data), PAR_ODD_BIT);
        end else begin
            parity_d = parity_q;
        end
    end

    // Parity bit register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    // Frame sequencer: next state, shifter, bit index and the line level
    // that o_tx must show once the next state is entered.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        o_tx_d    = o_tx_q;
        o_done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d   = START;
                    shift_d   = i_data;
                    bit_idx_d = 4'd0;
                    o_tx_d    = 1'b0;
                end else begin
                    state_d   = IDLE;
                    o_tx_d    = 1'b1;
                end
            end

            START: begin
                if (tick_s) begin
                    state_d = DATA;
                    o_tx_d  = shift_q[0];
                end else begin
                    o_tx_d  = 1'b0;
                end
            end

            DATA: begin
                if (tick_s) begin
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (bit_idx_q == LAST_DATA_IDX) begin
                        bit_idx_d = 4'd0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
                        o_tx_d    = parity_q;
`else
                        state_d   = STOP;
                        o_tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        o_tx_d    = shift_q[1];
                    end
                end else begin
                    o_tx_d = shift_q[0];
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick_s) begin
                    state_d   = STOP;
                    bit_idx_d = 4'd0;
                    o_tx_d    = 1'b1;
                end else begin
                    o_tx_d    = parity_q;
                end
            end
`endif

            STOP: begin
                if (tick_s) begin
                    if (bit_idx_q == LAST_STOP_IDX) begin
                        state_d  = IDLE;
                        o_done_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    bit_idx_d = bit_idx_q;
                end
                o_tx_d = 1'b1;
            end

            default: begin
                state_d = IDLE;
                o_tx_d  = 1'b1;
            end
        endcase
    end

    // Sequencer and output registers; reset returns the line to mark at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= {DATA_W{1'b0}};
            bit_idx_q <= 4'd0;
            o_tx_q    <= 1'b1;
            o_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            o_tx_q    <= o_tx_d;
            o_done_q  <= o_done_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q != IDLE);
    assign o_tx    = o_tx_q;
    assign o_done  = o_done_q;

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Parametrised UART transmitter, successor to the fixed 8N1 serialiser. It contains its own baud-rate divider, so it no longer needs an external baud clock or a finish strobe. It also adds configurable data width, stop-bit count and optional parity, plus a valid/ready input handshake. It sits between the TX FIFO (or any byte source) and the board TX pin.

## Interface
- CLK_DIV, default 434: system clocks per bit (50 MHz / 115200). Legal range ≥ 2.
- DATA_W, default 8: data bits per frame. Legal range 5..9.
- STOP_BITS, default 1: stop bits per frame, 1 or 2.
- PARITY_ODD, default 0: 0 = even parity, 1 = odd. Used only when UART_TX_PARITY_EN is defined.
- clk, in, 1: system clock; all logic is on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- i_data, in, DATA_W: word to send, LSB first.
- i_valid, in, 1: source has a word on i_data.
- o_ready, out, 1: block accepts a word this cycle.
- o_tx, out, 1: serial line. Idle level (mark) is 1.
- o_busy, out, 1: a frame is in progress.
- o_done, out, 1: one-cycle pulse at end of frame.

## Operation
- Single clock and asynchronous active-high reset, as already decided.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- Accept rule: a word is accepted when i_valid && o_ready.
  - o_ready is 1 only in IDLE.
  - On accept: latch i_data into a shift register, clear the baud counter and the bit index, and go to START.
- Baud counter: width $clog2(CLK_DIV), counts 0..CLK_DIV-1 and wraps. A tick fires when it equals CLK_DIV-1. Every line bit is held for exactly CLK_DIV clocks.
- State transitions, one per tick:
  - START drives 0, then goes to DATA.
  - DATA drives shift[0] and shifts right. After bit index DATA_W-1 it goes to PARITY, or to STOP if there is no parity.
  - PARITY drives ^data_latched ^ PARITY_ODD, then goes to STOP.
  - STOP drives 1 for STOP_BITS bit periods, then goes to IDLE.
- o_tx is registered. It equals the line level of the current state.
- o_busy = (state != IDLE).
- o_done is registered and high for exactly the cycle in which the state returns to IDLE.
- i_valid while busy is ignored; no queueing. Changes on i_data after accept are ignored.
- Reset values: o_tx=1, o_busy=0, o_done=0, state IDLE, so o_ready=1.
- Reset mid-frame: o_tx goes to 1 asynchronously, the frame is abandoned, and no o_done is issued.
- Illegal parameters (CLK_DIV<2, DATA_W outside 5..9, STOP_BITS not in {1,2}) must stop elaboration with a $error.

## Timing
- N = 1 + DATA_W + P + STOP_BITS, where P = 1 when parity is compiled in, else 0.
- For an accept in cycle T:
  - o_tx=0 from T+1 through T+CLK_DIV.
  - Data bit i occupies cycles T+1+(i+1)·CLK_DIV through T+(i+2)·CLK_DIV.
  - o_done=1 and o_ready=1 in cycle T+1+N·CLK_DIV.
- Back-to-back frames: if i_valid is held, the next accept happens in the o_done cycle. This gives exactly one clock of extra mark between frames.
- Latency from accept to start-bit edge: 1 clock.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state exists and one parity bit is sent after the data bits, even or odd per PARITY_ODD.
- Undefined: the PARITY state and parity logic are not compiled, PARITY_ODD is ignored, and frames are DATA_W-N-STOP_BITS.

## Structure
- Package uart_pkg holds:
  - typedef enum logic [2:0] uart_tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparams for the default CLK_DIV and the legal DATA_W limits.
  - The package is shared with the future RX core.
- Sub-module uart_baud_gen (parameter CLK_DIV, inputs clk, reset, clear; output tick) contains the divider. It is reused by RX at 16× oversampling.

## Test plan
- CLK_DIV=4, DATA_W=8, no parity, send 0x55: o_tx shows 0,1,0,1,0,1,0,1,0,1, each level 4 clocks. o_done comes 41 clocks after accept.
- Parity on, even, send 0x07 then 0x03: parity bit is 1 then 0. With PARITY_ODD=1 the bits are 0 then 1.
- i_valid held high with words 0xA5 and 0x3C: the second accept lands in the o_done cycle, with a 1-clock mark gap and no lost or duplicated word.
- Reset asserted in the middle of data bit 3: o_tx=1 in the same cycle, o_busy=0, no o_done. A fresh 0xFF after release is sent correctly.
- STOP_BITS=2, DATA_W=7, send 0x7F: frame is 10 bits, the stop level lasts 2·CLK_DIV clocks, and bit 7 is never driven.
- Toggle i_data and pulse i_valid during a busy frame: the output frame is unchanged and o_ready stays 0 until o_done.
